// File: rtl/ex_stage_ctrl.sv
// RV32I execute-stage controller: decodes the instruction, drives the external ALU,
// resolves branches/jumps and holds the result in a valid/ready EX/MEM register.
module ex_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_less,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_taken,
  output logic [31:0] out_target,
  output logic        out_misalign,
  output logic        out_illegal,
  output logic [31:0] out_pc
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLT  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SUB  = 4'b1011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Base ALU op for funct3 when funct7 selects the plain (non-alternate) form.
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [4:0]  rd_s;
  logic [31:0] i_imm_s;
  logic [31:0] u_imm_s;
  logic [31:0] j_imm_s;
  logic [31:0] b_imm_s;

  assign opcode_s = in_instr[6:0];
  assign funct3_s = in_instr[14:12];
  assign funct7_s = in_instr[31:25];
  assign rd_s     = in_instr[11:7];
  assign i_imm_s  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign u_imm_s  = {in_instr[31:12], 12'h000};
  assign j_imm_s  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
  assign b_imm_s  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};

  logic [31:0] alu_a_s;
  logic [31:0] alu_b_s;
  logic [3:0]  alu_ctrl_s;
  logic        illegal_s;
  logic        writes_s;
  logic        jump_s;
  logic        branch_s;
  logic        clr_lsb_s;
  logic [31:0] tgt_base_s;
  logic [31:0] tgt_off_s;

  // Instruction decode: ALU operands/op, legality and redirect adder inputs.
  always_comb begin
    alu_a_s    = 32'h0000_0000;
    alu_b_s    = 32'h0000_0000;
    alu_ctrl_s = ALU_ADD;
    illegal_s  = 1'b0;
    writes_s   = 1'b0;
    jump_s     = 1'b0;
    branch_s   = 1'b0;
    clr_lsb_s  = 1'b0;
    tgt_base_s = 32'h0000_0000;
    tgt_off_s  = 32'h0000_0000;
    case (opcode_s)
      OPC_OP: begin
        alu_a_s  = in_rs1;
        alu_b_s  = in_rs2;
        writes_s = 1'b1;
        if (funct7_s == F7_BASE) begin
          alu_ctrl_s = base_op(funct3_s);
        end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b000)) begin
          alu_ctrl_s = ALU_SUB;
        end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b101)) begin
          alu_ctrl_s = ALU_SRA;
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_OPIMM: begin
        alu_a_s  = in_rs1;
        alu_b_s  = i_imm_s;
        writes_s = 1'b1;
        case (funct3_s)
          3'b001: begin
            if (funct7_s == F7_BASE) begin
              alu_ctrl_s = ALU_SLL;
            end else begin
              illegal_s = 1'b1;
            end
          end
          3'b101: begin
            if (funct7_s == F7_BASE) begin
              alu_ctrl_s = ALU_SRL;
            end else if (funct7_s == F7_ALT) begin
              alu_ctrl_s = ALU_SRA;
            end else begin
              illegal_s = 1'b1;
            end
          end
          default: alu_ctrl_s = base_op(funct3_s);
        endcase
      end
      OPC_LUI: begin
        alu_b_s  = u_imm_s;
        writes_s = 1'b1;
      end
      OPC_AUIPC: begin
        alu_a_s  = in_pc;
        alu_b_s  = u_imm_s;
        writes_s = 1'b1;
      end
      OPC_JAL: begin
        alu_a_s    = in_pc;
        alu_b_s    = 32'h0000_0004;
        writes_s   = 1'b1;
        jump_s     = 1'b1;
        tgt_base_s = in_pc;
        tgt_off_s  = j_imm_s;
      end
      OPC_JALR: begin
        alu_a_s    = in_pc;
        alu_b_s    = 32'h0000_0004;
        writes_s   = 1'b1;
        jump_s     = 1'b1;
        clr_lsb_s  = 1'b1;
        tgt_base_s = in_rs1;
        tgt_off_s  = i_imm_s;
        if (funct3_s != 3'b000) begin
          illegal_s = 1'b1;
        end else begin
          illegal_s = 1'b0;
        end
      end
      OPC_BRANCH: begin
        alu_a_s    = in_rs1;
        alu_b_s    = in_rs2;
        branch_s   = 1'b1;
        tgt_base_s = in_pc;
        tgt_off_s  = b_imm_s;
        case (funct3_s)
          3'b110, 3'b111:   alu_ctrl_s = ALU_SLTU;
          3'b010, 3'b011:   illegal_s  = 1'b1;
          default:          alu_ctrl_s = ALU_SUB;
        endcase
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Unsigned branches read the SLTU result through the zero flag.
  logic cond_s;
  always_comb begin
    case (funct3_s)
      3'b000:  cond_s = alu_zero;
      3'b001:  cond_s = ~alu_zero;
      3'b100:  cond_s = alu_less;
      3'b101:  cond_s = ~alu_less;
      3'b110:  cond_s = ~alu_zero;
      3'b111:  cond_s = alu_zero;
      default: cond_s = 1'b0;
    endcase
  end

  logic [31:0] tgt_sum_s;
  logic [31:0] target_s;
  logic        taken_s;
  logic        we_s;
  logic        capture_s;

  assign tgt_sum_s = tgt_base_s + tgt_off_s;
  assign target_s  = clr_lsb_s ? {tgt_sum_s[31:1], 1'b0} : tgt_sum_s;
  assign taken_s   = ~illegal_s & (jump_s | (branch_s & cond_s));
  assign we_s      = writes_s & ~illegal_s & (rd_s != 5'd0);

  assign alu_a     = alu_a_s;
  assign alu_b     = alu_b_s;
  assign alu_ctrl  = illegal_s ? ALU_ADD : alu_ctrl_s;
  assign in_ready  = ~out_valid | out_ready;
  assign capture_s = in_valid & in_ready & ~flush;

  // EX/MEM register: reset beats flush, flush beats capture, otherwise drain or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_result   <= 32'h0000_0000;
      out_rd       <= 5'd0;
      out_we       <= 1'b0;
      out_taken    <= 1'b0;
      out_target   <= 32'h0000_0000;
      out_misalign <= 1'b0;
      out_illegal  <= 1'b0;
      out_pc       <= RESET_PC;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture_s) begin
      out_valid    <= 1'b1;
      out_result   <= alu_result;
      out_rd       <= rd_s;
      out_we       <= we_s;
      out_taken    <= taken_s;
      out_target   <= target_s;
      out_misalign <= taken_s & target_s[1];
      out_illegal  <= illegal_s;
      out_pc       <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Directed bench for ex_stage_ctrl with a behavioural ALU wired to the alu_* ports.
module tb_ex_stage_ctrl;

  localparam logic [31:0] RPC = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_ready;
  logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, alu_less;
  logic        out_valid, out_we, out_taken, out_misalign, out_illegal;
  logic [31:0] out_result, out_target, out_pc;
  logic [4:0]  out_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_stage_ctrl #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_less(alu_less),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_we(out_we), .out_taken(out_taken),
    .out_target(out_target), .out_misalign(out_misalign),
    .out_illegal(out_illegal), .out_pc(out_pc)
  );

  // Reference ALU.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0010: alu_result = {31'd0, alu_a < alu_b};
      4'b0011: alu_result = alu_a ^ alu_b;
      4'b0100: alu_result = alu_a | alu_b;
      4'b0111: alu_result = alu_a & alu_b;
      4'b1000: alu_result = alu_a << alu_b[4:0];
      4'b1001: alu_result = alu_a >> alu_b[4:0];
      4'b1010: alu_result = $signed(alu_a) >>> alu_b[4:0];
      4'b1011: alu_result = alu_a - alu_b;
      default: alu_result = 32'h0000_0000;
    endcase
  end
  assign alu_zero = (alu_result == 32'h0000_0000);
  assign alu_less = $signed(alu_a) < $signed(alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    in_rs1   = rs1;
    in_rs2   = rs2;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0000_0013; in_pc = 32'h0; in_rs1 = 32'h0; in_rs2 = 32'h0;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pc", out_pc, RPC);
    check("rst_result", out_result, 32'h0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADDI x5,x0,-1
    drive(32'hFFF0_0293, 32'h0000_0000, 32'h0, 32'h0);
    check("addi_ctrl", {28'd0, alu_ctrl}, 32'd0);
    check("addi_b", alu_b, 32'hFFFF_FFFF);
    tick();
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_result", out_result, 32'hFFFF_FFFF);
    check("addi_rd", {27'd0, out_rd}, 32'd5);
    check("addi_we", {31'd0, out_we}, 32'd1);

    // SUB x3,x1,x2 back-to-back
    drive(32'h4020_81B3, 32'h0000_0004, 32'd5, 32'd7);
    check("sub_ctrl", {28'd0, alu_ctrl}, 32'hB);
    tick();
    check("sub_result", out_result, 32'hFFFF_FFFE);
    check("sub_rd", {27'd0, out_rd}, 32'd3);

    // SRAI x4,x1,4
    drive(32'h4040_D213, 32'h0000_0008, 32'h8000_0000, 32'h0);
    check("srai_ctrl", {28'd0, alu_ctrl}, 32'hA);
    check("srai_shamt", {27'd0, alu_b[4:0]}, 32'd4);
    tick();
    check("srai_result", out_result, 32'hF800_0000);

    // BLTU x1,x2,+8
    drive(32'h0020_E463, 32'h0000_0100, 32'h0000_0001, 32'hFFFF_FFFF);
    check("bltu_ctrl", {28'd0, alu_ctrl}, 32'h2);
    tick();
    check("bltu_taken", {31'd0, out_taken}, 32'd1);
    check("bltu_target", out_target, 32'h0000_0108);
    check("bltu_we", {31'd0, out_we}, 32'd0);

    // BLT same operands: 1 < -1 is false
    drive(32'h0020_C463, 32'h0000_0100, 32'h0000_0001, 32'hFFFF_FFFF);
    check("blt_ctrl", {28'd0, alu_ctrl}, 32'hB);
    tick();
    check("blt_taken", {31'd0, out_taken}, 32'd0);
    check("blt_target", out_target, 32'h0000_0108);

    // JALR x1,0(x2)
    drive(32'h0001_00E7, 32'h0000_0040, 32'h0000_0203, 32'h0);
    tick();
    check("jalr_result", out_result, 32'h0000_0044);
    check("jalr_target", out_target, 32'h0000_0202);
    check("jalr_taken", {31'd0, out_taken}, 32'd1);
    check("jalr_misalign", {31'd0, out_misalign}, 32'd1);
    check("jalr_we", {31'd0, out_we}, 32'd1);

    // LUI x7,0x12345 then stall with JAL pending
    drive(32'h1234_53B7, 32'h0000_0050, 32'h0000_FFFF, 32'h0);
    check("lui_a", alu_a, 32'h0);
    tick();
    check("lui_result", out_result, 32'h1234_5000);
    out_ready = 1'b0;
    drive(32'h0100_00EF, 32'h0000_0200, 32'h0, 32'h0);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_result", out_result, 32'h1234_5000);
      check("stall_pc", out_pc, 32'h0000_0050);
      check("stall_in_ready_hold", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("jal_valid", {31'd0, out_valid}, 32'd1);
    check("jal_result", out_result, 32'h0000_0204);
    check("jal_target", out_target, 32'h0000_0210);
    check("jal_taken", {31'd0, out_taken}, 32'd1);
    check("jal_misalign", {31'd0, out_misalign}, 32'd0);
    check("jal_pc", out_pc, 32'h0000_0200);

    // flush with in_valid high
    flush = 1'b1;
    drive(32'hFFF0_0293, 32'h0000_0300, 32'h0, 32'h0);
    tick();
    flush = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);

    // illegal OP funct7=0100000 funct3=111, captured under stall, then reset
    out_ready = 1'b0;
    drive(32'h4000_71B3, 32'h0000_0310, 32'h1, 32'h2);
    check("illegal_ctrl", {28'd0, alu_ctrl}, 32'd0);
    tick();
    check("illegal_flag", {31'd0, out_illegal}, 32'd1);
    check("illegal_we", {31'd0, out_we}, 32'd0);
    check("illegal_taken", {31'd0, out_taken}, 32'd0);
    check("illegal_pc", out_pc, 32'h0000_0310);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_stall_valid", {31'd0, out_valid}, 32'd0);
    check("rst_stall_pc", out_pc, RPC);

    // load opcode is illegal; then drain with no new input
    out_ready = 1'b1;
    drive(32'h0000_2283, 32'h0000_0400, 32'h0, 32'h0);
    tick();
    check("lw_illegal", {31'd0, out_illegal}, 32'd1);
    check("lw_we", {31'd0, out_we}, 32'd0);
    in_valid = 1'b0;
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage_ctrl.md
Name: ex_stage_ctrl

Overview:
- Execute-stage controller for the RV32I core. It sits between the decode stage and the combinational ALU.
- Decodes the instruction word and drives the ALU's operand and control inputs (a, b, ctrl). It then consumes the ALU's result, zero flag and less-than flag.
- Resolves branches and jumps, and registers everything into a valid/ready EX/MEM pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into out_pc on reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  kill the held output and block capture this cycle
- in_valid  input  1  decode offers an instruction
- in_ready  output  1  stage can accept
- in_instr  input  32  instruction word
- in_pc  input  32  instruction address
- in_rs1  input  32  rs1 register value
- in_rs2  input  32  rs2 register value
- alu_a  output  32  ALU operand a
- alu_b  output  32  ALU operand b
- alu_ctrl  output  4  ALU operation code
- alu_result  input  32  ALU result
- alu_zero  input  1  ALU zero flag (result==0)
- alu_less  input  1  ALU signed a<b flag
- out_valid  output  1  EX/MEM register holds a valid entry
- out_ready  input  1  downstream accepts
- out_result  output  32  writeback value
- out_rd  output  5  destination register
- out_we  output  1  register write enable (0 when rd==0)
- out_taken  output  1  redirect required
- out_target  output  32  redirect address
- out_misalign  output  1  taken target with bit1 set
- out_illegal  output  1  unsupported or illegal encoding
- out_pc  output  32  pc of the held instruction

Behaviour:
- ALU codes:
  - 0000 ADD, 0001 SLT, 0010 SLTU, 0011 XOR, 0100 OR
  - 0111 AND, 1000 SLL, 1001 SRL, 1010 SRA, 1011 SUB
  - alu_ctrl is never driven to any other value; unknown encodings drive 0000.
- alu_a, alu_b and alu_ctrl are combinational from the in_* inputs. The stage samples the ALU outputs in the same cycle.
- OP (0110011):
  - a=rs1, b=rs2.
  - funct7=0100000 is legal only with funct3 000 (SUB) and 101 (SRA).
  - funct7=0000000 is legal for all funct3.
  - Any other funct7 -> illegal.
- OP-IMM (0010011):
  - a=rs1, b=sign-extended I-imm.
  - SLLI needs funct7=0000000; SRLI/SRAI are selected by instr[30] with the remaining funct7 bits zero. Otherwise illegal.
- LUI: a=0, b=U-imm, ADD.
- AUIPC: a=pc, b=U-imm, ADD.
- JAL:
  - ALU computes pc+4 (a=pc, b=4, ADD).
  - taken=1, target=pc+J-imm from a local adder.
- JALR (funct3 000 only):
  - ALU computes pc+4.
  - target=(rs1+I-imm)&~1 from a local adder; taken=1.
- BRANCH: out_we=0; target=pc+B-imm from a local adder. Compare per funct3:
  - BEQ: SUB, taken=zero.
  - BNE: SUB, taken=!zero.
  - BLT: SUB, taken=less.
  - BGE: SUB, taken=!less.
  - BLTU: SLTU, taken=!zero.
  - BGEU: SLTU, taken=zero.
  - funct3 010/011 -> illegal.
- Any other opcode, including load, store and system -> illegal.
- Entries flagged illegal are still captured with out_illegal=1, out_we=0, out_taken=0.
- out_misalign=out_taken & out_target[1].
- Handshake:
  - in_ready = !out_valid | out_ready. It is combinational and does not depend on in_valid.
  - Capture on in_valid & in_ready & !flush. Latency is 1 cycle, and there are no bubbles under continuous flow.
  - While out_valid & !out_ready, all out_* hold stable and in_ready=0.
  - The entry is consumed on out_valid & out_ready; with no new capture in the same cycle, out_valid->0.
- flush: next cycle out_valid=0, regardless of out_ready or in_valid. flush has priority over capture.
- Reset:
  - out_valid=0, out_result=0, out_rd=0, out_we=0, out_taken=0, out_target=0.
  - out_misalign=0, out_illegal=0, out_pc=RESET_PC.
  - Reset overrides flush and capture. Reset during a stall drops the held entry.
- All adders are 32-bit with wrap-around; carry out is discarded.

Test Plan:
- ADDI x5,x0,-1 (0xFFF00293), rs1=0 -> alu_ctrl=0000, b=0xFFFFFFFF; next cycle out_result=0xFFFFFFFF, out_rd=5, out_we=1.
- SUB x3,x1,x2, rs1=5, rs2=7 -> alu_ctrl=1011, out_result=0xFFFFFFFE. Then SRAI by 4 on 0x80000000 -> alu_ctrl=1010, b[4:0]=4, result 0xF8000000.
- BLTU with rs1=1, rs2=0xFFFFFFFF, pc=0x100, imm=+8 -> alu_ctrl=0010, out_taken=1, out_target=0x108, out_we=0. The same operands under BLT -> out_taken=0.
- JALR x1, rs1=0x203, imm=0, pc=0x40 -> out_result=0x44, out_target=0x202, out_taken=1, out_misalign=1.
- out_ready=0 for 3 cycles with in_valid=1 held -> in_ready=0 and out_* stable. On out_ready=1 the held entry drains and the next instruction is captured in the same edge.
- flush asserted together with in_valid=1 -> out_valid=0 next cycle. Then rst=1 during a stall -> out_valid=0, out_pc=RESET_PC. funct7=0100000 with funct3=111 -> out_illegal=1, out_we=0.
